// File: rtl/nvram_upload.sv
// nvram_upload: serves core-side NVRAM bytes to the HPS over the ioctl upload interface
module nvram_upload #(
    parameter int          AW     = 10,
    parameter int          SIZE   = 1024,
    parameter logic [7:0]  INDEX  = 8'd4,
    parameter int          RD_LAT = 1
) (
    input  logic          clk_sys,
    input  logic          RESET_N,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          pause_req,
    input  logic          pause_ack,
    output logic          ram_req,
    output logic [AW-1:0] ram_addr,
    input  logic          ram_gnt,
    input  logic [7:0]    ram_dout,
    output logic          busy
);
    typedef enum logic [2:0] {IDLE, PAUSING, READY, FETCH, LAT} state_t;

    state_t        state, state_nx;
    logic          rst_meta, rst_n;
    logic          upload_q;
    logic          pend, pend_nx;
    logic [1:0]    lat_cnt, lat_cnt_nx;
    logic [AW-1:0] ram_addr_nx;
    logic [7:0]    din_nx;
    logic          in_range, start, last_lat;

    assign in_range = ioctl_addr < 25'(SIZE);
    assign start    = ioctl_upload && !upload_q && ioctl_index == INDEX;
    assign last_lat = lat_cnt == 2'(RD_LAT - 1);
    assign busy     = state != IDLE;

    // reset asserts immediately and releases two clk_sys edges later
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    // state and datapath registers; upload_q resets high so a level held through reset is not a start edge
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            upload_q  <= 1'b1;
            pend      <= 1'b0;
            lat_cnt   <= 2'd0;
            ram_addr  <= '0;
            ioctl_din <= 8'h00;
        end else begin
            state     <= state_nx;
            upload_q  <= ioctl_upload;
            pend      <= pend_nx;
            lat_cnt   <= lat_cnt_nx;
            ram_addr  <= ram_addr_nx;
            ioctl_din <= din_nx;
        end
    end

    // next-state and handshake outputs; a read arriving while paused is held until the core acks
    always_comb begin
        state_nx    = state;
        pend_nx     = pend;
        lat_cnt_nx  = lat_cnt;
        ram_addr_nx = ram_addr;
        din_nx      = ioctl_din;
        pause_req   = 1'b0;
        ioctl_wait  = 1'b0;
        ram_req     = 1'b0;
        case (state)
            IDLE: begin
                pend_nx = 1'b0;
                if (start) state_nx = PAUSING;
            end
            PAUSING: begin
                pause_req  = 1'b1;
                ioctl_wait = 1'b1;
                if (ioctl_rd && !pend && in_range) begin
                    pend_nx     = 1'b1;
                    ram_addr_nx = ioctl_addr[AW-1:0];
                end
                if (ioctl_rd && !pend && !in_range) din_nx = 8'hFF;
                if (pause_ack) begin
                    state_nx = pend_nx ? FETCH : READY;
                    pend_nx  = 1'b0;
                end
            end
            READY: begin
                pause_req = 1'b1;
                if (ioctl_rd && in_range) ram_addr_nx = ioctl_addr[AW-1:0];
                if (ioctl_rd && !in_range) din_nx = 8'hFF;
                if (!pause_ack) begin
                    state_nx = PAUSING;
                    pend_nx  = ioctl_rd && in_range;
                end else if (ioctl_rd && in_range) begin
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                pause_req  = 1'b1;
                ioctl_wait = 1'b1;
                ram_req    = 1'b1;
                if (ram_gnt) begin
                    state_nx   = LAT;
                    lat_cnt_nx = 2'd0;
                end
            end
            LAT: begin
                pause_req  = 1'b1;
                ioctl_wait = 1'b1;
                if (last_lat) begin
                    din_nx   = ram_dout;
                    state_nx = pause_ack ? READY : PAUSING;
                end else begin
                    lat_cnt_nx = lat_cnt + 2'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (state != IDLE && !ioctl_upload) begin
            state_nx = IDLE;
            pend_nx  = 1'b0;
            din_nx   = ioctl_din;
        end
    end
endmodule

// File: tb/tb_nvram_upload.sv
// tb_nvram_upload: directed bench with a transaction-level model checked every cycle
module tb_nvram_upload;
    localparam int RD_LAT = 1;

    logic        clk_sys = 1'b0;
    logic        RESET_N = 1'b0;
    logic        ioctl_upload = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait, pause_req, ram_req, busy;
    logic        pause_ack = 1'b0;
    logic        ram_gnt = 1'b1;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_dout = 8'h00;
    logic [7:0]  mem [1024];
    int          vectors = 0;
    int          miscompares = 0;
    int          n;

    always #5 clk_sys = ~clk_sys;

    nvram_upload #(.AW(10), .SIZE(1024), .INDEX(8'd4), .RD_LAT(RD_LAT)) dut (
        .clk_sys(clk_sys), .RESET_N(RESET_N), .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .pause_req(pause_req),
        .pause_ack(pause_ack), .ram_req(ram_req), .ram_addr(ram_addr),
        .ram_gnt(ram_gnt), .ram_dout(ram_dout), .busy(busy)
    );

    // RAM with one cycle of read latency after an accepted request
    always @(posedge clk_sys) ram_dout <= (ram_req && ram_gnt) ? mem[ram_addr] : 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: session, halted core, at most one outstanding job, returned byte
    bit         m_sess, m_halted, m_job, m_gnt, m_up_prev;
    int         m_lat;
    logic [9:0] m_addr;
    logic [7:0] m_din;

    always @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            m_sess = 0; m_halted = 0; m_job = 0; m_gnt = 0; m_up_prev = 1; m_lat = 0;
            m_addr = '0; m_din = 8'h00;
        end else begin
            if (m_sess && !ioctl_upload) begin
                m_sess = 0; m_job = 0; m_gnt = 0;
            end else if (!m_sess) begin
                if (ioctl_upload && !m_up_prev && ioctl_index == 8'd4) begin
                    m_sess = 1; m_halted = 0; m_job = 0; m_gnt = 0;
                end
            end else if (m_gnt) begin
                m_lat--;
                if (m_lat == 0) begin
                    m_din = mem[m_addr]; m_job = 0; m_gnt = 0; m_halted = pause_ack;
                end
            end else if (m_job && m_halted) begin
                if (ram_gnt) begin m_gnt = 1; m_lat = RD_LAT; end
            end else begin
                if (ioctl_rd && !m_job) begin
                    if (ioctl_addr < 25'd1024) begin m_job = 1; m_addr = ioctl_addr[9:0]; end
                    else m_din = 8'hFF;
                end
                m_halted = pause_ack;
            end
            m_up_prev = ioctl_upload;
        end
    end

    // every-cycle comparison against the model, away from the clock edge
    always @(posedge clk_sys) begin
        #2;
        check("busy", busy, m_sess);
        check("pause_req", pause_req, m_sess);
        check("ioctl_wait", ioctl_wait, m_sess && (!m_halted || m_job));
        check("ram_req", ram_req, m_sess && m_halted && m_job && !m_gnt);
        check("ioctl_din", ioctl_din, m_din);
        if (m_sess && m_halted && m_job && !m_gnt) check("ram_addr", ram_addr, m_addr);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic rd(input logic [24:0] a);
        ioctl_rd = 1'b1;
        ioctl_addr = a;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
    endtask

    task automatic measure_wait(input int release_at, output int cnt);
        cnt = 0;
        while (ioctl_wait && cnt < 50) begin
            cnt++;
            if (cnt == release_at) ram_gnt = 1'b1;
            @(negedge clk_sys);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
        mem[10'h123] = 8'hA5;
        mem[10'h2F0] = 8'h3C;
        mem[10'h010] = 8'h5E;
        repeat (3) tick();
        RESET_N = 1'b1;
        repeat (5) tick();
        check("reset_busy", busy, 0);
        check("reset_din", ioctl_din, 8'h00);
        check("reset_ram_addr", ram_addr, 0);
        // session start, ack three cycles later
        ioctl_index = 8'd4;
        ioctl_upload = 1'b1;
        n = 0;
        repeat (3) begin tick(); n += int'(ioctl_wait); end
        check("start_wait_cycles", n, 3);
        pause_ack = 1'b1;
        tick();
        check("ready_wait", ioctl_wait, 0);
        check("ready_busy", busy, 1);
        // fast path
        rd(25'h123);
        measure_wait(0, n);
        check("fast_wait_cycles", n, 2);
        check("fast_din", ioctl_din, 8'hA5);
        // grant delayed five cycles
        ram_gnt = 1'b0;
        rd(25'h2F0);
        measure_wait(6, n);
        check("slow_wait_cycles", n, 7);
        check("slow_din", ioctl_din, 8'h3C);
        // out-of-range reads
        rd(25'd1024);
        check("oor1024_din", ioctl_din, 8'hFF);
        check("oor1024_wait", ioctl_wait, 0);
        check("oor1024_req", ram_req, 0);
        rd(25'h010);
        measure_wait(0, n);
        check("mid_din", ioctl_din, 8'h5E);
        rd(25'h1FFFFFF);
        check("oormax_din", ioctl_din, 8'hFF);
        check("oormax_req", ram_req, 0);
        // back-to-back strobes: out of range then in range
        ioctl_rd = 1'b1;
        ioctl_addr = 25'd2000;
        tick();
        check("b2b_din", ioctl_din, 8'hFF);
        ioctl_addr = 25'h123;
        tick();
        ioctl_rd = 1'b0;
        measure_wait(0, n);
        check("b2b_wait_cycles", n, 2);
        check("b2b_din2", ioctl_din, 8'hA5);
        // ack drops mid-fetch: fetch completes, then back to pausing
        ram_gnt = 1'b0;
        rd(25'h010);
        pause_ack = 1'b0;
        tick();
        tick();
        ram_gnt = 1'b1;
        tick();
        tick();
        check("ackdrop_wait", ioctl_wait, 1);
        check("ackdrop_din", ioctl_din, 8'h5E);
        pause_ack = 1'b1;
        tick();
        check("ackback_wait", ioctl_wait, 0);
        // upload dropped during latency
        rd(25'h2F0);
        tick();
        ioctl_upload = 1'b0;
        tick();
        check("drop_wait", ioctl_wait, 0);
        check("drop_pause", pause_req, 0);
        check("drop_req", ram_req, 0);
        check("drop_busy", busy, 0);
        check("drop_din", ioctl_din, 8'h5E);
        tick();
        ioctl_index = 8'd3;
        ioctl_upload = 1'b1;
        repeat (3) tick();
        check("idx3_busy", busy, 0);
        check("idx3_pause", pause_req, 0);
        ioctl_upload = 1'b0;
        ioctl_index = 8'd4;
        tick();
        // asynchronous reset mid-fetch
        ioctl_upload = 1'b1;
        tick();
        tick();
        ram_gnt = 1'b0;
        rd(25'h123);
        tick();
        check("prereset_req", ram_req, 1);
        #2 RESET_N = 1'b0;
        #1;
        check("areset_req", ram_req, 0);
        check("areset_wait", ioctl_wait, 0);
        check("areset_pause", pause_req, 0);
        check("areset_busy", busy, 0);
        check("areset_din", ioctl_din, 8'h00);
        check("areset_addr", ram_addr, 0);
        tick();
        tick();
        RESET_N = 1'b1;
        ram_gnt = 1'b1;
        repeat (6) tick();
        check("postreset_busy", busy, 0);
        ioctl_upload = 1'b0;
        tick();
        ioctl_upload = 1'b1;
        tick();
        check("restart_busy", busy, 1);
        ioctl_upload = 1'b0;
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
